// File: rtl/regfile_wb_sched.sv
// Writeback scheduler and hazard scoreboard in front of the Registers block.
// Shares the single register-file write port between returning loads and ALU
// results. ALU results that cannot be written immediately wait in a small FIFO.
// A scoreboard of in-flight load destinations drives the decode stall.
module regfile_wb_sched #(
    parameter int WIDTH      = 32,
    parameter int REG_AW     = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_alu_valid,
    input  logic [4:0]       i_alu_rd,
    input  logic [WIDTH-1:0] i_alu_data,
    output logic             o_alu_ready,
    input  logic             i_ld_issue,
    input  logic [4:0]       i_ld_issue_rd,
    input  logic             i_ld_valid,
    input  logic [4:0]       i_ld_rd,
    input  logic [WIDTH-1:0] i_ld_data,
    input  logic [4:0]       i_rs_a,
    input  logic [4:0]       i_rs_b,
    input  logic [4:0]       i_rd,
    output logic             o_stall,
    output logic             o_regwrite,
    output logic [4:0]       o_wr_addr,
    output logic [WIDTH-1:0] o_wr_data,
    output logic             o_sb_err
);

    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = PW + 1;
    localparam int NREG = 1 << REG_AW;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // Register indices as seen by the register file (upper address bits alias away)
    logic [REG_AW-1:0] alu_idx;
    logic [REG_AW-1:0] ld_idx;
    logic [REG_AW-1:0] issue_idx;
    logic [REG_AW-1:0] rs_a_idx;
    logic [REG_AW-1:0] rs_b_idx;
    logic [REG_AW-1:0] rd_idx;
    logic              unused_addr_bits;

    assign alu_idx   = i_alu_rd[REG_AW-1:0];
    assign ld_idx    = i_ld_rd[REG_AW-1:0];
    assign issue_idx = i_ld_issue_rd[REG_AW-1:0];
    assign rs_a_idx  = i_rs_a[REG_AW-1:0];
    assign rs_b_idx  = i_rs_b[REG_AW-1:0];
    assign rd_idx    = i_rd[REG_AW-1:0];
    assign unused_addr_bits = ^{i_alu_rd[4:REG_AW], i_ld_rd[4:REG_AW], i_ld_issue_rd[4:REG_AW],
                                i_rs_a[4:REG_AW], i_rs_b[4:REG_AW], i_rd[4:REG_AW]};

    // ALU holding FIFO
    logic [REG_AW-1:0] fifo_rd_q   [FIFO_DEPTH];
    logic [REG_AW-1:0] fifo_rd_d   [FIFO_DEPTH];
    logic [WIDTH-1:0]  fifo_data_q [FIFO_DEPTH];
    logic [WIDTH-1:0]  fifo_data_d [FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    // Scoreboard and registered write port
    logic [NREG-1:0]   pending_q, pending_d;
    logic              sb_err_q, sb_err_d;
    logic              regwrite_q, regwrite_d;
    logic [4:0]        wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]  wr_data_q, wr_data_d;

    // Arbitration scratch
    logic              alu_acc;
    logic              push;
    logic              pop;
    logic              win;
    logic [REG_AW-1:0] win_rd;
    logic [WIDTH-1:0]  win_data;
    logic [PW-1:0]     scan_idx;

    assign o_alu_ready = (count_q < DEPTH_C);
    assign o_regwrite  = regwrite_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data   = wr_data_q;
    assign o_sb_err    = sb_err_q;

    // Pick the write-port winner (load, then FIFO head, then a direct ALU result) and update the FIFO
    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        regwrite_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        push        = 1'b0;
        pop         = 1'b0;
        win         = 1'b0;
        win_rd      = '0;
        win_data    = '0;
        alu_acc     = i_alu_valid & o_alu_ready;

        if (i_ld_valid) begin
            win      = 1'b1;
            win_rd   = ld_idx;
            win_data = i_ld_data;
            push     = alu_acc;
        end else if (count_q != '0) begin
            win      = 1'b1;
            win_rd   = fifo_rd_q[rd_ptr_q];
            win_data = fifo_data_q[rd_ptr_q];
            pop      = 1'b1;
            push     = alu_acc;
        end else if (alu_acc) begin
            win      = 1'b1;
            win_rd   = alu_idx;
            win_data = i_alu_data;
        end

        regwrite_d = win && (win_rd != '0);
        if (win) begin
            wr_addr_d = {{(5-REG_AW){1'b0}}, win_rd};
            wr_data_d = win_data;
        end

        if (push) begin
            fifo_rd_d[wr_ptr_q]   = alu_idx;
            fifo_data_d[wr_ptr_q] = i_alu_data;
            wr_ptr_d              = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Scoreboard: a returning load clears its bit, a new issue sets one (set wins on a collision)
    always_comb begin
        pending_d = pending_q;
        sb_err_d  = sb_err_q;
        if (i_ld_valid) begin
            if (!pending_q[ld_idx]) begin
                sb_err_d = 1'b1;
            end
            pending_d[ld_idx] = 1'b0;
        end
        if (i_ld_issue && (issue_idx != '0)) begin
            pending_d[issue_idx] = 1'b1;
        end
    end

    // Decode stall from registered state: pending loads, queued ALU results, and the write in flight
    always_comb begin
        o_stall  = 1'b0;
        scan_idx = '0;
        if ((rs_a_idx != '0) && pending_q[rs_a_idx]) o_stall = 1'b1;
        if ((rs_b_idx != '0) && pending_q[rs_b_idx]) o_stall = 1'b1;
        if ((rd_idx   != '0) && pending_q[rd_idx])   o_stall = 1'b1;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if (CW'(k) < count_q) begin
                scan_idx = rd_ptr_q + PW'(k);
                if ((fifo_rd_q[scan_idx] == rs_a_idx) || (fifo_rd_q[scan_idx] == rs_b_idx)) begin
                    o_stall = 1'b1;
                end
            end
        end
        if (regwrite_q && ((wr_addr_q[REG_AW-1:0] == rs_a_idx) || (wr_addr_q[REG_AW-1:0] == rs_b_idx))) begin
            o_stall = 1'b1;
        end
    end

    // State registers; reset empties the FIFO, clears the scoreboard and idles the write port
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            fifo_rd_q   <= '{default: '0};
            fifo_data_q <= '{default: '0};
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            pending_q   <= '0;
            sb_err_q    <= 1'b0;
            regwrite_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            fifo_rd_q   <= fifo_rd_d;
            fifo_data_q <= fifo_data_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            sb_err_q    <= sb_err_d;
            regwrite_q  <= regwrite_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

endmodule
